// File: rtl/apb_vec_acc.sv
// apb_vec_acc: APB3 slave holding A/B/R word buffers and a sequencer that
// computes R[i] = A[i] (op) B[i] lane-wise, one word per cycle.

// One lane of the datapath. Carries and borrows stay inside the lane.
module apb_vec_acc_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  input  logic [1:0]        i_mode,
  output logic [LANE_W-1:0] o_y
);
  logic [LANE_W:0] w_sum;
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Select add / sub / unsigned saturating add / xor
  always_comb begin
    case (i_mode)
      2'd0:    o_y = w_sum[LANE_W-1:0];
      2'd1:    o_y = i_a - i_b;
      2'd2:    o_y = w_sum[LANE_W] ? '1 : w_sum[LANE_W-1:0];
      default: o_y = i_a ^ i_b;
    endcase
  end
endmodule

module apb_vec_acc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DEPTH          = 64,
  parameter int LANE_W         = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      irq_o
);
  localparam int         NUM_LANES = 32 / LANE_W;
  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH9    = 9'(DEPTH);
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RUN     = 1'b1;

  logic [0:0]  r_state;
  logic [8:0]  r_idx;
  logic [1:0]  r_mode;
  logic [8:0]  r_len;
  logic        r_irq_en;
  logic        r_done;
  logic        r_err;
  logic        r_irq;

  logic [31:0] r_a [DEPTH];
  logic [31:0] r_b [DEPTH];
  logic [31:0] r_r [DEPTH];

  // Address decode: PADDR[11:10] selects regs/A/B/R, PADDR[9:2] the word.
  logic [1:0] w_rgn;
  logic [7:0] w_k;
  logic       w_k_ok;
  logic       w_unused_addr;
  assign w_rgn         = PADDR[11:10];
  assign w_k           = PADDR[9:2];
  assign w_k_ok        = {1'b0, w_k} < DEPTH9;
  assign w_unused_addr = ^PADDR[1:0];

  logic w_wr, w_busy;
  logic w_wr_ctrl, w_wr_stat, w_wr_len, w_wr_ien, w_wr_a, w_wr_b;
  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_busy    = (r_state == S_RUN);
  assign w_wr_ctrl = w_wr & (w_rgn == 2'd0) & (w_k == 8'd0);
  assign w_wr_stat = w_wr & (w_rgn == 2'd0) & (w_k == 8'd1);
  assign w_wr_len  = w_wr & (w_rgn == 2'd0) & (w_k == 8'd2);
  assign w_wr_ien  = w_wr & (w_rgn == 2'd0) & (w_k == 8'd3);
  assign w_wr_a    = w_wr & (w_rgn == 2'd1) & w_k_ok;
  assign w_wr_b    = w_wr & (w_rgn == 2'd2) & w_k_ok;

  // Sequencer events. ABORT dominates START when both bits are set.
  logic w_abort, w_start, w_len_ok, w_go, w_bad, w_kill, w_step, w_finish;
  assign w_abort  = w_wr_ctrl & PWDATA[1];
  assign w_start  = w_wr_ctrl & PWDATA[0] & ~PWDATA[1];
  assign w_len_ok = (r_len != 9'd0) && (r_len <= DEPTH9);
  assign w_go     = ~w_busy & w_start & w_len_ok;
  assign w_bad    = ~w_busy & w_start & ~w_len_ok;
  assign w_kill   = w_busy & w_abort;
  // An abort suppresses the R write of the cycle it lands in.
  assign w_step   = w_busy & ~w_kill;
  assign w_finish = w_step & (r_idx == r_len - 9'd1);

  assign PREADY  = 1'b1;
  assign PSLVERR = w_busy & (w_wr_a | w_wr_b | w_wr_len | w_wr_ien |
                             (w_wr_ctrl & ~PWDATA[1]));

  // Next values of the flags; a hardware set beats a same-cycle W1C.
  logic w_done_nx, w_err_nx, w_ien_nx;
  always_comb begin
    w_done_nx = r_done;
    w_err_nx  = r_err;
    if (w_go) begin
      w_done_nx = 1'b0;
      w_err_nx  = 1'b0;
    end else begin
      if (w_bad | w_kill | w_finish) w_done_nx = 1'b1;
      else if (w_wr_stat & PWDATA[1]) w_done_nx = 1'b0;
      if (w_bad | w_kill)             w_err_nx = 1'b1;
      else if (w_wr_stat & PWDATA[2]) w_err_nx = 1'b0;
    end
    w_ien_nx = (~w_busy & w_wr_ien) ? PWDATA[0] : r_irq_en;
  end

  // Lane-parallel datapath on the current word.
  logic [31:0]                      w_opa, w_opb, w_res;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_la, w_lb, w_ly;
  assign w_opa = r_a[r_idx[IW-1:0]];
  assign w_opb = r_b[r_idx[IW-1:0]];
  assign w_la  = w_opa;
  assign w_lb  = w_opb;
  assign w_res = w_ly;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    apb_vec_acc_lane #(.LANE_W(LANE_W)) u_lane (
      .i_a    (w_la[g]),
      .i_b    (w_lb[g]),
      .i_mode (r_mode),
      .o_y    (w_ly[g])
    );
  end

  // Control state, config registers and the registered interrupt.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_mode   <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_go)                    r_state <= S_RUN;
      else if (w_kill | w_finish)  r_state <= S_IDLE;
      if (w_go)                    r_idx <= '0;
      else if (w_step)             r_idx <= r_idx + 9'd1;
      if (~w_busy & w_wr_ctrl)     r_mode <= PWDATA[3:2];
      if (~w_busy & w_wr_len)      r_len <= PWDATA[8:0];
      r_irq_en <= w_ien_nx;
      r_done   <= w_done_nx;
      r_err    <= w_err_nx;
      r_irq    <= w_done_nx & w_ien_nx;
    end
  end

  // Buffer storage, deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (w_wr_a & ~w_busy) r_a[w_k[IW-1:0]] <= PWDATA;
    if (w_wr_b & ~w_busy) r_b[w_k[IW-1:0]] <= PWDATA;
    if (w_step)           r_r[r_idx[IW-1:0]] <= w_res;
  end

  assign irq_o = r_irq;

  // Read mux; unmapped and out-of-range words read 0.
  always_comb begin
    PRDATA = '0;
    case (w_rgn)
      2'd0: begin
        case (w_k)
          8'd0:    PRDATA = {28'd0, r_mode, 2'b00};
          8'd1:    PRDATA = {29'd0, r_err, r_done, w_busy};
          8'd2:    PRDATA = {23'd0, r_len};
          8'd3:    PRDATA = {31'd0, r_irq_en};
          default: PRDATA = '0;
        endcase
      end
      2'd1:    if (w_k_ok) PRDATA = r_a[w_k[IW-1:0]];
      2'd2:    if (w_k_ok) PRDATA = r_b[w_k[IW-1:0]];
      default: if (w_k_ok) PRDATA = r_r[w_k[IW-1:0]];
    endcase
  end
endmodule

// File: tb/tb_apb_vec_acc.sv
// tb_apb_vec_acc: randomized jobs plus directed corner cases, checked against
// a word/lane arithmetic model of the accelerator.
module tb_apb_vec_acc;
  localparam int DEPTH = 64;
  localparam int LW    = 8;
  localparam logic [11:0] A_CTRL = 12'h000, A_STAT = 12'h004, A_LEN = 12'h008,
                          A_IEN = 12'h00C, A_ABUF = 12'h400, A_BBUF = 12'h800,
                          A_RBUF = 12'hC00;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq_o;

  int n_vec = 0, n_err = 0;
  int cyc = 0, rise_cyc = 0, rise_cnt = 0;
  int t_acc = 0, t_start = 0, rc0 = 0;
  logic irq_q = 1'b0;

  logic [31:0] mA [DEPTH];
  logic [31:0] mB [DEPTH];
  logic [31:0] mR [DEPTH];

  apb_vec_acc #(.APB_ADDR_WIDTH(12), .DEPTH(DEPTH), .LANE_W(LW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  // Record the edge index at which irq_o last rose.
  always @(negedge HCLK) begin
    if (irq_o && !irq_q) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    irq_q <= irq_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane arithmetic straight from the mode definitions.
  function automatic logic [31:0] f_op(input logic [31:0] a, input logic [31:0] b, input int mode);
    longint unsigned m, x, y, r;
    logic [31:0] res;
    m = (64'd1 << LW) - 1;
    res = '0;
    for (int j = 0; j < 32 / LW; j++) begin
      x = (longint'(a) >> (j * LW)) & m;
      y = (longint'(b) >> (j * LW)) & m;
      case (mode)
        0: r = (x + y) & m;
        1: r = (x + m + 1 - y) & m;
        2: r = (x + y > m) ? m : x + y;
        default: r = x ^ y;
      endcase
      res = res | 32'(r << (j * LW));
    end
    return res;
  endfunction

  // All bus tasks start just after a rising edge; access edge = that edge + 2.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(negedge HCLK); err = PSLVERR;
    @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    t_acc = cyc;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(negedge HCLK); d = PRDATA;
    @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic load_ab(input int n);
    for (int k = 0; k < n; k++) begin
      mA[k] = $urandom; mB[k] = $urandom;
      wr(A_ABUF + 12'(4 * k), mA[k]);
      wr(A_BBUF + 12'(4 * k), mB[k]);
    end
  endtask

  task automatic start_job(input int len, input int mode);
    wr(A_LEN, 32'(len));
    rc0 = rise_cnt;
    wr(A_CTRL, 32'((mode << 2) | 1));
    t_start = t_acc;
  endtask

  task automatic wait_irq(input string tag, input int exp_lat);
    for (int c = 0; c < 300 && rise_cnt == rc0; c++) begin
      @(posedge HCLK); #1;
    end
    chk(tag, (rise_cnt != rc0) ? 32'(rise_cyc - t_start) : 32'hFFFF_FFFF, 32'(exp_lat));
  endtask

  task automatic model_apply(input int n, input int mode);
    for (int k = 0; k < n; k++) mR[k] = f_op(mA[k], mB[k], mode);
  endtask

  task automatic check_r(input string tag);
    for (int k = 0; k < DEPTH; k++) rd_chk($sformatf("%s_R%0d", tag, k), A_RBUF + 12'(4 * k), mR[k]);
  endtask

  task automatic full_job(input string tag, input int len, input int mode);
    load_ab(DEPTH);
    start_job(len, mode);
    wait_irq({tag, "_lat"}, len);
    model_apply(len, mode);
    check_r(tag);
    rd_chk({tag, "_stat"}, A_STAT, 32'h2);
  endtask

  initial begin
    logic e;
    logic [31:0] d;
    int mode;

    #3;
    chk("rst_pready", 32'(PREADY), 32'h1);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    #20 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_stat", A_STAT, 32'h0);
    rd_chk("rst_len", A_LEN, 32'h0);
    rd_chk("rst_ien", A_IEN, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);

    wr(A_IEN, 32'h1);
    full_job("fill", DEPTH, int'($urandom_range(0, 3)));

    // Directed add then saturate on word 0.
    mA[0] = 32'h01FF7F10; mB[0] = 32'h01018020;
    wr(A_ABUF, mA[0]); wr(A_BBUF, mB[0]);
    start_job(1, 0);
    wait_irq("add_lat", 1);
    rd_chk("add_stat", A_STAT, 32'h2);
    rd_chk("add_r0", A_RBUF, 32'h0200FF30);
    rd_chk("add_r1", A_RBUF + 12'h4, mR[1]);
    start_job(1, 2);
    wait_irq("sat_lat", 1);
    rd_chk("sat_r0", A_RBUF, 32'h02FFFF30);
    mR[0] = 32'h02FFFF30;
    rd_chk("sat_ctrl", A_CTRL, 32'h8);

    // Randomized jobs, one at the full-depth boundary.
    for (int j = 0; j < 4; j++) begin
      mode = int'($urandom_range(0, 3));
      full_job($sformatf("rnd%0d", j), (j == 3) ? DEPTH : int'($urandom_range(1, DEPTH)), mode);
    end

    // Busy lock: writes rejected, mode cannot change mid-run.
    load_ab(DEPTH);
    start_job(DEPTH, 1);
    apb_wr(A_ABUF + 12'h14, 32'hDEADBEEF, e); chk("busy_a_err", 32'(e), 32'h1);
    apb_wr(A_LEN, 32'h5, e);                  chk("busy_len_err", 32'(e), 32'h1);
    apb_wr(A_CTRL, 32'hD, e);                 chk("busy_ctrl_err", 32'(e), 32'h1);
    apb_wr(A_IEN, 32'h0, e);                  chk("busy_ien_err", 32'(e), 32'h1);
    apb_wr(A_RBUF, 32'h0, e);                 chk("busy_rbuf_err", 32'(e), 32'h0);
    rd_chk("busy_stat", A_STAT, 32'h1);
    wait_irq("busy_lat", DEPTH);
    rd_chk("busy_a5", A_ABUF + 12'h14, mA[5]);
    rd_chk("busy_len", A_LEN, 32'(DEPTH));
    rd_chk("busy_stat_end", A_STAT, 32'h2);
    model_apply(DEPTH, 1);
    check_r("busy");

    // Abort at T+10: R[0..8] new, rest kept.
    load_ab(DEPTH);
    mode = int'($urandom_range(0, 3));
    start_job(DEPTH, mode);
    repeat (8) @(posedge HCLK);
    #1;
    apb_wr(A_CTRL, 32'h2, e);
    chk("abort_err", 32'(e), 32'h0);
    wait_irq("abort_lat", 10);
    model_apply(9, mode);
    check_r("abort");
    rd_chk("abort_stat", A_STAT, 32'h6);
    chk("abort_irq", 32'(irq_o), 32'h1);

    // W1C: clear DONE only, then ERR.
    wr(A_STAT, 32'h2);
    rd_chk("w1c_done", A_STAT, 32'h4);
    chk("w1c_irq", 32'(irq_o), 32'h0);
    wr(A_STAT, 32'h4);
    rd_chk("w1c_err", A_STAT, 32'h0);

    // Bad lengths.
    start_job(0, 0);
    rd_chk("len0_stat", A_STAT, 32'h6);
    chk("len0_irq", 32'(irq_o), 32'h1);
    wr(A_STAT, 32'h6);
    rd_chk("len0_clr", A_STAT, 32'h0);
    chk("len0_irq_clr", 32'(irq_o), 32'h0);
    start_job(DEPTH + 1, 0);
    rd_chk("len65_stat", A_STAT, 32'h6);
    wr(A_STAT, 32'h6);

    // Idle abort, START+ABORT together, R write, unmapped space.
    wr(A_LEN, 32'h4);
    apb_wr(A_CTRL, 32'h2, e);          chk("idle_abort_err", 32'(e), 32'h0);
    rd_chk("idle_abort_stat", A_STAT, 32'h0);
    apb_wr(A_CTRL, 32'h3, e);          chk("startabort_err", 32'(e), 32'h0);
    rd_chk("startabort_stat", A_STAT, 32'h0);
    apb_wr(A_RBUF, 32'h12345678, e);   chk("rwr_err", 32'(e), 32'h0);
    rd_chk("rwr_r0", A_RBUF, mR[0]);
    apb_wr(12'h010, 32'hFFFFFFFF, e);  chk("unmap_err", 32'(e), 32'h0);
    rd_chk("unmap_rd", 12'h010, 32'h0);
    apb_wr(A_ABUF + 12'h100, 32'h1, e); chk("oor_err", 32'(e), 32'h0);
    rd_chk("oor_rd", A_ABUF + 12'h100, 32'h0);

    // Reset mid-run.
    wr(A_IEN, 32'h1);
    start_job(DEPTH, 0);
    repeat (5) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    chk("mrst_pready", 32'(PREADY), 32'h1);
    chk("mrst_pslverr", 32'(PSLVERR), 32'h0);
    chk("mrst_irq", 32'(irq_o), 32'h0);
    #10 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd_chk("mrst_stat", A_STAT, 32'h0);
    rd_chk("mrst_len", A_LEN, 32'h0);
    chk("mrst_irq2", 32'(irq_o), 32'h0);
    start_job(0, 0);
    rd_chk("mrst_len0_stat", A_STAT, 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apb_vec_acc.md
APB_VEC_ACC -- requirements
Module: apb_vec_acc

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, sets the APB address width; only PADDR[11:0] is decoded.
REQ-002 Parameter DEPTH, default 64, sets the words per operand/result buffer; legal range is 1..256.
REQ-003 Parameter LANE_W, default 8, sets the lane width in bits; legal values are 8, 16 and 32; lanes per word = 32/LANE_W.
REQ-004 HCLK  in  1  clock; all state updates on its rising edge.
REQ-005 HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 PADDR  in  APB_ADDR_WIDTH  byte address; decode is word-based on PADDR[11:2].
REQ-007 PWDATA  in  32  write data.
REQ-008 PWRITE, PSEL, PENABLE  in  1 each  APB3 controls.
REQ-009 PRDATA  out  32  read data, combinational from the decoded address.
REQ-010 PREADY  out  1  tied to 1 (zero wait states).
REQ-011 PSLVERR  out  1  error response, combinational, valid only during the access phase.
REQ-012 irq_o  out  1  registered interrupt, level-high.

Function
REQ-013 An access is PSEL&PENABLE; a write is an access with PWRITE=1.
REQ-014 Address map:
- 0x000 CTRL: bit0 START (write-only, self-clearing, reads 0); bit1 ABORT (write-only, self-clearing, reads 0); bits[3:2] MODE (R/W).
- 0x004 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C).
- 0x008 LEN: bits[8:0], R/W, word count.
- 0x00C IRQ_EN: bit0, R/W.
- 0x400 A buffer, 0x800 B buffer, 0xC00 R buffer; word k at base+4k for k<DEPTH.
REQ-015 A and B are R/W; R is read-only from APB, and writes to R are ignored with PSLVERR=0.
REQ-016 Unmapped addresses, and buffer words k>=DEPTH, read 0 and ignore writes, with PSLVERR=0.
REQ-017 FSM states and transitions:
- IDLE -> RUN on a write to CTRL with START=1 and 1<=LEN<=DEPTH.
- IDLE -> IDLE with ERR<=1 and DONE<=1 on START when LEN=0 or LEN>DEPTH.
- RUN -> IDLE when the last word is written, or on ABORT.
REQ-018 START clears DONE and ERR and loads index i<=0 on the same edge.
REQ-019 In RUN, each cycle computes R[i] from A[i] and B[i] lane-wise, writes it at the cycle-ending edge, and increments i; throughput is one word per cycle.
REQ-020 MODE encoding, applied independently per lane with no carry between lanes:
- 0: add, wrap modulo 2^LANE_W.
- 1: sub, wrap.
- 2: unsigned saturating add, clamping to 2^LANE_W-1.
- 3: xor.
REQ-021 Latency: with START accepted at edge T, R[i] is written at edge T+1+i; BUSY=0 and DONE=1 hold from edge T+LEN.
REQ-022 BUSY=1 exactly while in RUN.
REQ-023 While BUSY, writes to A, B, LEN or IRQ_EN, and CTRL writes with ABORT=0, have no effect and assert PSLVERR=1.
REQ-024 Reads are always allowed and never error; an R read during RUN returns the current contents.
REQ-025 ABORT in RUN: the next state is IDLE, ERR<=1, DONE<=1, and R words not yet written keep their old values.
REQ-026 ABORT in IDLE is a no-op with PSLVERR=0.
REQ-027 A CTRL write with both START=1 and ABORT=1 is treated as ABORT only.
REQ-028 If a DONE W1C write and a hardware DONE set occur on the same edge, the set wins; the same rule applies to ERR.
REQ-029 irq_o <= DONE_next & IRQ_EN_next, registered, so it follows DONE and IRQ_EN with no extra cycle.
REQ-030 MODE is sampled continuously in RUN but cannot change there (locked by REQ-023).

Reset
REQ-031 HRESETn low asynchronously forces: state IDLE, i=0, MODE=0, LEN=0, IRQ_EN=0, DONE=0, ERR=0, irq_o=0.
REQ-032 Buffer contents are not reset.
REQ-033 A reset asserted mid-RUN aborts immediately and sets no flags.
REQ-034 PREADY=1 and PSLVERR=0 hold during reset.

Verification
REQ-035 Add lanes (LANE_W=8, DEPTH=64): A[0]=0x01FF7F10, B[0]=0x01018020, LEN=1, MODE=0, START -> R[0]=0x0200FF30; DONE=1 at T+1; BUSY=0.
REQ-036 Saturate: same operands, MODE=2 -> R[0]=0x02FFFF30.
REQ-037 Busy lock: LEN=64, START, then write A[5] on the next cycle -> PSLVERR=1, A[5] unchanged, BUSY=1 until T+64, then DONE=1.
REQ-038 Abort: LEN=64, START, ABORT at T+10 -> R[0..8] updated, R[9..63] unchanged, ERR=1, DONE=1, irq_o=1 when IRQ_EN=1.
REQ-039 Bad length: LEN=0 then START -> ERR=1, DONE=1, BUSY never 1; W1C 0x6 to STATUS -> STATUS reads 0.
REQ-040 Reset mid-RUN at T+5 -> STATUS=0, irq_o=0, LEN=0; a subsequent START with LEN=0 sets ERR.
